// File: rtl/pma_classifier_pkg.sv
// Shared PMA definitions: region base/mask constants, region and access-type codes,
// and the decoded response record carried through the classifier FIFO.
package pma_classifier_pkg;

  localparam int CFG_CPU_ADDR_BITS = 48;

  // A region hits when the address bits above its mask equal the base address.
  localparam logic [CFG_CPU_ADDR_BITS-1:0] CLINT_BAR  = 48'h0000_0200_0000;
  localparam logic [CFG_CPU_ADDR_BITS-1:0] CLINT_MASK = 48'h0000_0000_FFFF;
  localparam logic [CFG_CPU_ADDR_BITS-1:0] PLIC_BAR   = 48'h0000_0C00_0000;
  localparam logic [CFG_CPU_ADDR_BITS-1:0] PLIC_MASK  = 48'h0000_03FF_FFFF;
  localparam logic [CFG_CPU_ADDR_BITS-1:0] IO1_BAR    = 48'h0000_1000_0000;
  localparam logic [CFG_CPU_ADDR_BITS-1:0] IO1_MASK   = 48'h0000_000F_FFFF;

  localparam logic [1:0] REGION_MEM   = 2'd0;
  localparam logic [1:0] REGION_CLINT = 2'd1;
  localparam logic [1:0] REGION_PLIC  = 2'd2;
  localparam logic [1:0] REGION_IO1   = 2'd3;

  localparam logic [1:0] ACC_READ  = 2'd0;
  localparam logic [1:0] ACC_WRITE = 2'd1;
  localparam logic [1:0] ACC_EXEC  = 2'd2;
  localparam logic [1:0] ACC_RSRV  = 2'd3;

  typedef struct packed {
    logic [CFG_CPU_ADDR_BITS-1:0] addr;
    logic [1:0]                   region;
    logic                         cached;
    logic                         fault;
  } pma_resp_type;

  function automatic logic region_hit(input logic [CFG_CPU_ADDR_BITS-1:0] addr,
                                      input logic [CFG_CPU_ADDR_BITS-1:0] bar,
                                      input logic [CFG_CPU_ADDR_BITS-1:0] mask);
    return (addr & ~mask) == bar;
  endfunction

endpackage

// File: rtl/pma_region_decode.sv
// Combinational address/access-type decoder producing the PMA response record.
module pma_region_decode
  import pma_classifier_pkg::*;
(
  input  logic [CFG_CPU_ADDR_BITS-1:0] i_addr,
  input  logic [1:0]                   i_type,
  output pma_resp_type                 o_resp
);

  logic [1:0] w_region;

  // Regions are disjoint, so priority order only matters for resolving "no hit" to MEM.
  always_comb begin
    w_region = REGION_MEM;
    if (region_hit(i_addr, CLINT_BAR, CLINT_MASK)) begin
      w_region = REGION_CLINT;
    end else if (region_hit(i_addr, PLIC_BAR, PLIC_MASK)) begin
      w_region = REGION_PLIC;
    end else if (region_hit(i_addr, IO1_BAR, IO1_MASK)) begin
      w_region = REGION_IO1;
    end
  end

  always_comb begin
    o_resp.addr   = i_addr;
    o_resp.region = w_region;
    o_resp.cached = (w_region == REGION_MEM);
    o_resp.fault  = (i_type == ACC_RSRV) ||
                    ((i_type == ACC_EXEC) && (w_region != REGION_MEM));
  end

endmodule

// File: rtl/pma_classifier.sv
// Registered PMA stage: decodes each accepted request into a 2-entry response FIFO
// and keeps a saturating count of faulting requests for debug.
module pma_classifier
  import pma_classifier_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [CFG_CPU_ADDR_BITS-1:0] i_req_addr,
  input  logic [1:0]                   i_req_type,
  output logic                         o_resp_valid,
  input  logic                         i_resp_ready,
  output logic [CFG_CPU_ADDR_BITS-1:0] o_resp_addr,
  output logic [1:0]                   o_resp_region,
  output logic                         o_resp_cached,
  output logic                         o_resp_fault,
  input  logic                         i_fault_clr,
  output logic [CNT_BITS-1:0]          o_fault_cnt
);

  logic [1:0]          r_count;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  pma_resp_type        r_mem [2];
  logic [CNT_BITS-1:0] r_fault_cnt;

  pma_resp_type w_dec;
  pma_resp_type w_head;
  logic         w_push;
  logic         w_pop;

  pma_region_decode u_decode (
    .i_addr (i_req_addr),
    .i_type (i_req_type),
    .o_resp (w_dec)
  );

  // Ready depends only on stored occupancy (and reset), never on the consumer side.
  assign o_req_ready  = i_nrst && (r_count < 2'd2);
  assign o_resp_valid = (r_count != 2'd0);
  assign w_push       = i_req_valid && o_req_ready;
  assign w_pop        = o_resp_valid && i_resp_ready;

  assign w_head        = r_mem[r_rd_ptr];
  assign o_resp_addr   = w_head.addr;
  assign o_resp_region = w_head.region;
  assign o_resp_cached = w_head.cached;
  assign o_resp_fault  = w_head.fault;
  assign o_fault_cnt   = r_fault_cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_fault_cnt <= '0;
    end else if (i_fault_clr) begin
      r_fault_cnt <= '0;
    end else if (w_push && w_dec.fault && (r_fault_cnt != {CNT_BITS{1'b1}})) begin
      r_fault_cnt <= r_fault_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pma_classifier.md
Name: pma_classifier

Overview:
- Registered physical-memory-attribute stage between the cache miss/uncached request path and the bus.
- Each request address is matched against the PMA region constants in the shared PMA package: CLINT, PLIC and IO1 base-address/mask pairs.
- For each request it emits:
  - a region code;
  - a cacheability flag;
  - an access-fault flag.
- Results pass through a 2-entry response FIFO with valid/ready on both sides. A saturating fault counter is available for debug.

Parameters:
- CNT_BITS, 16, width of the saturating fault counter.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  stage can accept a request.
- i_req_addr  in  CFG_CPU_ADDR_BITS  physical address (48 bits).
- i_req_type  in  2  access type: 0 read, 1 write, 2 execute, 3 reserved.
- o_resp_valid  out  1  head FIFO entry valid.
- i_resp_ready  in  1  consumer takes the head entry.
- o_resp_addr  out  CFG_CPU_ADDR_BITS  echoed address.
- o_resp_region  out  2  region code: 0 MEM, 1 CLINT, 2 PLIC, 3 IO1.
- o_resp_cached  out  1  1 only when the region is MEM.
- o_resp_fault  out  1  access fault.
- i_fault_clr  in  1  clear the fault counter.
- o_fault_cnt  out  CNT_BITS  count of accepted faulting requests.

Behaviour:
- Reset (i_nrst=0, asynchronous): FIFO count=0, write/read pointers=0, fault counter=0.
  - Output values under reset: o_resp_valid=0, o_req_ready=0, o_resp_addr=0, o_resp_region=0, o_resp_cached=0, o_resp_fault=0, o_fault_cnt=0.
  - A reset asserted mid-operation discards all queued entries immediately.
- o_req_ready:
  - 1 when FIFO count < 2.
  - Registered-state only; no combinational path from i_resp_ready.
  - A full FIFO being popped in the same cycle does not accept a request.
- Accept: i_req_valid && o_req_ready. On accept, the decode result is written into the FIFO at wr_ptr on the same edge.
- Latency: a response is visible on o_resp_valid exactly 1 cycle after accept when the FIFO was empty. Throughput: 1 request per cycle.
- Decode (combinational, pre-register):
  - Region hit rule: (addr & ~MASK) == BAR, evaluated for each of CLINT, PLIC, IO1.
  - Regions are disjoint; if none hits, the region is MEM.
  - cached = (region == MEM).
  - fault = 1 when either condition holds:
    - type == 3, in any region;
    - type == 2 and region != MEM (no execute from IO).
- Pop: o_resp_valid && i_resp_ready; rd_ptr advances.
- Simultaneous push and pop: count unchanged. When count was 1, the new entry becomes head on the next cycle with no bubble.
- Output fields are driven from the head entry. They are stable while o_resp_valid=1 and i_resp_ready=0.
- Pointers are 1 bit and wrap 1→0.
- Fault counter:
  - Increments on every accepted faulting request.
  - Saturates at 2^CNT_BITS-1.
  - i_fault_clr has priority: in a cycle where clear and an increment coincide, the counter becomes 0.

Decomposition:
- PMA package: region BAR/MASK constants, region-code localparams, access-type localparams.
- Shared package for the module: a packed struct pma_resp_type {addr, region, cached, fault}.
- One natural sub-module: pma_region_decode, the combinational address/type → pma_resp_type decoder. The FIFO and counter stay in pma_classifier.

Test Plan:
- Reset then read 0x000080000000 → resp 1 cycle later: region 0, cached 1, fault 0.
- Reads at 0x000002000000, 0x00000200FFFF, 0x000002010000 → regions 1, 1, 0. Cached is 0 for the first two and 1 for the third.
- Execute at 0x00000C000004, then at 0x000010000000 → regions 2 and 3, both fault=1; o_fault_cnt=2. Write at 0x0000100FFFFF → region 3, fault 0.
- Type 3 at 0x0 → fault 1; counter increments. Assert i_fault_clr in the same cycle as a faulting accept → counter reads 0.
- Hold i_resp_ready=0 with 3 back-to-back requests → the first two are accepted, then o_req_ready=0. Raise i_resp_ready → responses drain in order with unchanged fields, and the third request is accepted the cycle after the first pop.
- Deassert i_nrst with 2 entries queued → o_resp_valid=0 immediately; after release, count=0 and o_req_ready=1.
- With CNT_BITS=2, issue 5 faults → o_fault_cnt saturates at 3.
